mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Byte-serial memory arbiter for the five-stage pipeline. It shares one byte-wide, single-port synchronous RAM between instruction fetch (IF) and the load/store stage (MEM). It assembles or splits 8/16/32-bit little-endian transfers and raises per-stage stall requests to the pipeline controller. This keeps the inter-stage registers (if_id … mem_wb) frozen while a transfer is in flight.

## Interface
Parameters:
- ADDR_W, 32, width of ram_a; the low ADDR_W bits of the computed byte address are driven.

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset (asserted = `RstEnable)
- if_req  in  1  IF wants a 32-bit fetch
- if_addr  in  32  IF byte address
- if_data  out  32  fetched word
- if_done  out  1  one-cycle completion pulse for IF
- mem_req  in  1  MEM wants a transfer
- mem_we  in  1  1 = store, 0 = load
- mem_len  in  2  0 = byte, 1 = half, 2 = word, 3 = treated as word
- mem_addr  in  32  MEM byte address
- mem_wdata  in  32  store data; low N bytes used
- mem_rdata  out  32  load data, zero-extended (sign extension is done in MEM)
- mem_done  out  1  one-cycle completion pulse for MEM
- ram_a  out  ADDR_W  RAM byte address
- ram_dout  out  8  RAM write byte
- ram_wr  out  1  RAM write enable
- ram_din  in  8  RAM read byte, valid the cycle after its address
- stallreq_if  out  1  IF stall request to ctrl
- stallreq_mem  out  1  MEM stall request to ctrl
- busy  out  1  state != IDLE

## Operation
- States: IDLE, RD, WR, DONE. Registers: owner (IF/MEM), byte count, length N (1/2/4), base address, data assembly register.
- IDLE: at each edge, sample the requests. mem_req has fixed priority over if_req. The grant latches owner, address, N and wdata, then moves to RD (load or IF) or WR (store). With no request, stay in IDLE.
- There is no preemption. Requests are ignored outside IDLE.
- RD, cycles k = 1..N: ram_a = base+k-1, ram_wr = 0.
- RD, cycle N+1: no new address; ram_a holds its last value.
- RD, byte capture: ram_din captured at the end of cycle k+1 into byte lane k-1.
- RD, final step: after the last capture, go to DONE.
- WR, cycles k = 1..N: ram_a = base+k-1, ram_dout = wdata[8(k-1)+7 : 8(k-1)], ram_wr = 1. After cycle N, go to DONE.
- DONE, one cycle: owner's done = 1. On a read, the owner's data output is updated, with lanes ≥ N zero. Then go to IDLE unconditionally, so a requester has one edge to drop or change its request.
- if_data and mem_rdata hold their value until that owner's next read completes. Stores leave mem_rdata unchanged.
- Address arithmetic is modulo 2^32, then truncated to ADDR_W bits. No alignment is required.
- stallreq_if = if_req & ~if_done; stallreq_mem = mem_req & ~mem_done (combinational).
- Reset: state = IDLE; if_data, mem_rdata, ram_a, ram_dout = 0; if_done, mem_done, ram_wr, busy = 0. An in-flight transfer is abandoned without a done pulse. Store bytes already written stay written.

## Timing
- Reference: edge E0 ends the IDLE cycle in which the request is sampled; cycle 1 follows it.
- Read of N bytes: done in cycle N+2 (word: cycle 6; half: 4; byte: 3). IDLE again in cycle N+3.
- Write of N bytes: ram_wr high in cycles 1..N; done in cycle N+1.
- Back-to-back requests: the second transfer is sampled at the end of the IDLE cycle following DONE. Minimum period is N+3 cycles for a read and N+2 for a write.
- Simultaneous if_req and mem_req in IDLE: MEM first. IF is granted at the IDLE edge after MEM's DONE if still requesting.
- ram_a, ram_dout, ram_wr, done pulses and data outputs are registered. Only stallreq_* are combinational.

## Test plan
- IF fetch at 0x00001000, RAM bytes 13 05 00 00 -> ram_a = 0x1000..0x1003 in cycles 1-4, ram_wr = 0; if_done only in cycle 6; if_data = 0x00000513; stallreq_if high cycles 0-5.
- Simultaneous if_req @0x0 and mem load word @0x2000 -> mem_done in cycle 6, ram_a never 0x0 before cycle 8, if_done in cycle 13, stallreq_if high throughout.
- Store byte mem_addr 0x3003, wdata 0xAABBCCDD -> cycle 1: ram_a = 0x3003, ram_dout = 0xDD, ram_wr = 1; mem_done cycle 2. Store word @0x3000, 0x11223344 -> ram_dout 44, 33, 22, 11 in cycles 1-4; mem_done cycle 5.
- Half load @0x4000, bytes 80 FF -> mem_rdata = 0x0000FF80, mem_done cycle 4; if_data unchanged.
- rst high in cycle 3 of a word fetch -> next cycle busy = 0, ram_wr = 0, if_data = 0; no if_done pulse; a fresh request afterwards completes normally.
- Word read @0xFFFFFFFE -> ram_a = FFFFFFFE, FFFFFFFF, 00000000, 00000001; data assembled little-endian.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares a byte-wide sync RAM between IF (if_*) and MEM (mem_*), driving ram_* and raising stallreq_* / busy
module mem_arbiter #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [31:0]       if_addr,
  output logic [31:0]       if_data,
  output logic              if_done,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [1:0]        mem_len,
  input  logic [31:0]       mem_addr,
  input  logic [31:0]       mem_wdata,
  output logic [31:0]       mem_rdata,
  output logic              mem_done,
  output logic [ADDR_W-1:0] ram_a,
  output logic [7:0]        ram_dout,
  output logic              ram_wr,
  input  logic [7:0]        ram_din,
  output logic              stallreq_if,
  output logic              stallreq_mem,
  output logic              busy
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RD   = 2'd1;
  localparam logic [1:0] S_WR   = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;
  logic [1:0]        state_q, state_d;
  logic              own_mem_q, own_mem_d;
  logic [2:0]        cnt_q, cnt_d, len_q, len_d, gnt_len;
  logic [31:0]       base_q, base_d, wdata_q, wdata_d, asm_q, asm_d;
  logic [31:0]       if_data_d, mem_rdata_d, gnt_addr, nxt_addr, ins;
  logic              if_done_d, mem_done_d, ram_wr_d;
  logic [ADDR_W-1:0] ram_a_d;
  logic [7:0]        ram_dout_d;
  logic [1:0]        lane;
  assign busy         = state_q != S_IDLE;
  assign stallreq_if  = if_req & ~if_done;
  assign stallreq_mem = mem_req & ~mem_done;
  always_comb begin
    gnt_addr    = mem_req ? mem_addr : if_addr;
    gnt_len     = !mem_req ? 3'd4 : mem_len == 2'd0 ? 3'd1 : mem_len == 2'd1 ? 3'd2 : 3'd4;
    nxt_addr    = base_q + {29'd0, cnt_q};
    lane        = cnt_q[1:0] - 2'd2;
    ins         = asm_q | ({24'd0, ram_din} << {lane, 3'b000});
    state_d     = state_q;
    own_mem_d   = own_mem_q;
    cnt_d       = cnt_q;
    len_d       = len_q;
    base_d      = base_q;
    wdata_d     = wdata_q;
    asm_d       = asm_q;
    if_data_d   = if_data;
    mem_rdata_d = mem_rdata;
    if_done_d   = 1'b0;
    mem_done_d  = 1'b0;
    ram_wr_d    = 1'b0;
    ram_a_d     = ram_a;
    ram_dout_d  = ram_dout;
    case (state_q)
      S_IDLE: if (mem_req | if_req) begin
        own_mem_d  = mem_req;
        base_d     = gnt_addr;
        len_d      = gnt_len;
        wdata_d    = mem_wdata;
        asm_d      = 32'd0;
        cnt_d      = 3'd1;
        ram_a_d    = gnt_addr[ADDR_W-1:0];
        ram_wr_d   = mem_req & mem_we;
        ram_dout_d = mem_req & mem_we ? mem_wdata[7:0] : ram_dout;
        state_d    = mem_req & mem_we ? S_WR : S_RD;
      end
      S_RD: begin
        cnt_d = cnt_q + 3'd1;
        if (cnt_q >= 3'd2) asm_d = ins;
        if (cnt_q < len_q) ram_a_d = nxt_addr[ADDR_W-1:0];
        if (cnt_q == len_q + 3'd1) begin
          state_d     = S_DONE;
          if_data_d   = own_mem_q ? if_data : ins;
          mem_rdata_d = own_mem_q ? ins : mem_rdata;
          if_done_d   = ~own_mem_q;
          mem_done_d  = own_mem_q;
        end
      end
      S_WR: if (cnt_q < len_q) begin
        ram_a_d    = nxt_addr[ADDR_W-1:0];
        ram_dout_d = wdata_q[{cnt_q[1:0], 3'b000} +: 8];
        ram_wr_d   = 1'b1;
        cnt_d      = cnt_q + 3'd1;
      end else begin
        state_d    = S_DONE;
        mem_done_d = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      own_mem_q <= 1'b0;
      cnt_q     <= 3'd0;
      len_q     <= 3'd0;
      base_q    <= 32'd0;
      wdata_q   <= 32'd0;
      asm_q     <= 32'd0;
      if_data   <= 32'd0;
      mem_rdata <= 32'd0;
      if_done   <= 1'b0;
      mem_done  <= 1'b0;
      ram_wr    <= 1'b0;
      ram_a     <= '0;
      ram_dout  <= 8'd0;
    end else begin
      state_q   <= state_d;
      own_mem_q <= own_mem_d;
      cnt_q     <= cnt_d;
      len_q     <= len_d;
      base_q    <= base_d;
      wdata_q   <= wdata_d;
      asm_q     <= asm_d;
      if_data   <= if_data_d;
      mem_rdata <= mem_rdata_d;
      if_done   <= if_done_d;
      mem_done  <= mem_done_d;
      ram_wr    <= ram_wr_d;
      ram_a     <= ram_a_d;
      ram_dout  <= ram_dout_d;
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: randomized and directed check of mem_arbiter against a transaction-level RAM model
module tb_mem_arbiter;
  logic        clk, rst, if_req, if_done, mem_req, mem_we, mem_done, ram_wr;
  logic        stallreq_if, stallreq_mem, busy;
  logic [1:0]  mem_len;
  logic [31:0] if_addr, if_data, mem_addr, mem_wdata, mem_rdata, ram_a;
  logic [7:0]  ram_dout, ram_din;
  logic [7:0]  ram [logic [31:0]];
  logic [7:0]  ref_mem [logic [31:0]];
  logic [31:0] exp_if, exp_mem;
  int          n_chk, n_fail;
  mem_arbiter #(.ADDR_W(32)) dut (
    .clk(clk), .rst(rst), .if_req(if_req), .if_addr(if_addr), .if_data(if_data), .if_done(if_done),
    .mem_req(mem_req), .mem_we(mem_we), .mem_len(mem_len), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_done(mem_done), .ram_a(ram_a), .ram_dout(ram_dout), .ram_wr(ram_wr),
    .ram_din(ram_din), .stallreq_if(stallreq_if), .stallreq_mem(stallreq_mem), .busy(busy)
  );
  always #5 clk = ~clk;
  function automatic logic [7:0] dflt(input logic [31:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5a;
  endfunction
  function automatic logic [7:0] ram_rd(input logic [31:0] a);
    return ram.exists(a) ? ram[a] : dflt(a);
  endfunction
  function automatic logic [7:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
  endfunction
  function automatic logic [31:0] ref_word(input logic [31:0] a, input int n);
    logic [31:0] w;
    w = 32'd0;
    for (int i = 0; i < n; i++) w = w | ({24'd0, ref_rd(a + i)} << (8 * i));
    return w;
  endfunction
  always @(posedge clk) begin
    if (ram_wr) ram[ram_a] = ram_dout;
    ram_din <= ram_rd(ram_a);
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic preset(input logic [31:0] a, input logic [7:0] b);
    ram[a] = b;
    ref_mem[a] = b;
  endtask
  task automatic run(input bit m, input bit we, input int n, input logic [31:0] a, input logic [31:0] wd);
    logic [31:0] exp;
    int dc;
    dc = we ? n + 1 : n + 2;
    exp = ref_word(a, n);
    if (m) begin
      mem_req = 1; mem_we = we; mem_addr = a; mem_wdata = wd;
      mem_len = n == 1 ? 2'd0 : n == 2 ? 2'd1 : 2'($urandom_range(2, 3));
    end else begin
      if_req = 1; if_addr = a;
    end
    #1 chk("stall0", m ? stallreq_mem : stallreq_if, 1);
    for (int c = 1; c <= dc; c++) begin
      @(negedge clk);
      if (c <= n) begin
        chk("ram_a", ram_a, a + c - 1);
        chk("ram_wr", ram_wr, we);
        if (we) chk("ram_dout", ram_dout, wd[8 * (c - 1) +: 8]);
      end
      chk("done", m ? mem_done : if_done, c == dc);
      chk("other_done", m ? if_done : mem_done, 0);
      chk("stall", m ? stallreq_mem : stallreq_if, c != dc);
      chk("busy", busy, 1);
    end
    if (m) mem_req = 0; else if_req = 0;
    if (we) for (int i = 0; i < n; i++) ref_mem[a + i] = wd[8 * i +: 8];
    else if (m) exp_mem = exp;
    else exp_if = exp;
    chk("if_data", if_data, exp_if);
    chk("mem_rdata", mem_rdata, exp_mem);
    @(negedge clk);
    chk("idle", busy, 0);
  endtask
  initial begin
    logic [31:0] exi, exm;
    n_chk = 0; n_fail = 0;
    clk = 0; rst = 1; if_req = 0; mem_req = 0; mem_we = 0; mem_len = 0;
    if_addr = 0; mem_addr = 0; mem_wdata = 0; exp_if = 0; exp_mem = 0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_wr", ram_wr, 0);
    chk("rst_a", ram_a, 0);
    chk("rst_dout", ram_dout, 0);
    chk("rst_ifd", if_data, 0);
    chk("rst_memd", mem_rdata, 0);
    chk("rst_done", {if_done, mem_done}, 0);
    rst = 0;
    @(negedge clk);
    preset(32'h1000, 8'h13); preset(32'h1001, 8'h05); preset(32'h1002, 8'h00); preset(32'h1003, 8'h00);
    preset(32'h4000, 8'h80); preset(32'h4001, 8'hff);
    run(0, 0, 4, 32'h1000, 0);
    chk("fetch_val", if_data, 32'h00000513);
    exi = ref_word(32'h0, 4);
    exm = ref_word(32'h2000, 4);
    mem_req = 1; mem_we = 0; mem_len = 2; mem_addr = 32'h2000; if_req = 1; if_addr = 32'h0;
    #1 chk("sim_stall0", stallreq_if, 1);
    for (int c = 1; c <= 13; c++) begin
      @(negedge clk);
      chk("sim_mdone", mem_done, c == 6);
      chk("sim_idone", if_done, c == 13);
      chk("sim_stall_if", stallreq_if, c != 13);
      if (c < 8) chk("sim_a_not0", ram_a != 0, 1);
      if (c >= 8 && c <= 11) chk("sim_if_a", ram_a, c - 8);
      if (c == 6) begin
        mem_req = 0;
        chk("sim_mdata", mem_rdata, exm);
      end
    end
    if_req = 0;
    exp_if = exi; exp_mem = exm;
    chk("sim_idata", if_data, exi);
    @(negedge clk);
    run(1, 1, 1, 32'h3003, 32'haabbccdd);
    run(1, 1, 4, 32'h3000, 32'h11223344);
    run(1, 0, 4, 32'h3000, 0);
    chk("st_back", mem_rdata, 32'h11223344);
    exi = if_data;
    run(1, 0, 2, 32'h4000, 0);
    chk("half_val", mem_rdata, 32'h0000ff80);
    chk("half_ifkeep", if_data, exi);
    run(0, 0, 4, 32'hfffffffe, 0);
    chk("wrap_val", if_data, ref_word(32'hfffffffe, 4));
    if_req = 1; if_addr = 32'h1000;
    repeat (3) @(negedge clk);
    rst = 1; if_req = 0;
    @(negedge clk);
    chk("rr_busy", busy, 0);
    chk("rr_wr", ram_wr, 0);
    chk("rr_ifd", if_data, 0);
    chk("rr_done", if_done, 0);
    rst = 0; exp_if = 0; exp_mem = 0;
    @(negedge clk);
    chk("rr_nodone", if_done, 0);
    run(0, 0, 4, 32'h1000, 0);
    for (int t = 0; t < 40; t++) begin
      bit m, we;
      int n;
      logic [31:0] a;
      m = 1'($urandom % 2);
      we = m ? 1'($urandom % 2) : 1'b0;
      n = m ? (1 << $urandom_range(0, 2)) : 4;
      a = ($urandom % 4 == 0) ? 32'hfffffffc + ($urandom % 4) : 32'h5000 + ($urandom % 64);
      run(m, we, n, a, $urandom);
      repeat ($urandom % 3) @(negedge clk);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
